// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: write-size encoding, arbiter
// states, the latched request record and small width helpers.
package mem_pkg;

  // Widest address/data the latched request record can carry.
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    WS_BYTE = 2'd0,
    WS_HALF = 2'd1,
    WS_WORD = 2'd2
  } ws_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    ws_t                   ws;
    logic                  wr;
  } mem_req_t;

  // Bits needed to index n items, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count 0..t, never less than one.
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel picker: round-robin scan starting at a pointer, or
// fixed priority (lowest index first). Masked channels are never picked.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_rr_mode,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  localparam logic [PW:0] N_L = (PW+1)'(N);

  logic [N-1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  // Walk the channels from the scan start and take the first eligible one
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      if (i_rr_mode) begin
        sum = {1'b0, i_ptr} + (PW+1)'(k);
        if (sum >= N_L) sum = sum - N_L;
        pos = sum[PW-1:0];
      end else begin
        pos = PW'(k);
      end
      if (!o_any && w_elig[pos]) begin
        o_any        = 1'b1;
        o_grant[pos] = 1'b1;
        o_idx        = pos;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NCH req/rdy cache channels onto one downstream memory port.
// A granted request is latched, presented to memory until mem_rdy (or a
// timeout), and completed with a one-cycle rdy pulse to its channel. The
// channel that just completed sits out the next arbitration cycle.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH*ADDR_W-1:0] ch_addr,
  input  logic [NCH*DATA_W-1:0] ch_wdata,
  input  logic [NCH*2-1:0]      ch_ws,
  input  logic [NCH-1:0]        ch_wr,
  input  logic [NCH-1:0]        ch_req,
  output logic [DATA_W-1:0]     ch_rdata,
  output logic [NCH-1:0]        ch_rdy,
  output logic                  ch_err,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [1:0]            mem_ws,
  output logic                  mem_wr,
  output logic                  mem_req,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rdy
);

  localparam int PW    = idx_w(NCH);
  localparam int TW    = cnt_w(TIMEOUT);
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [PW-1:0] LAST_CH = PW'(NCH - 1);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  mem_req_t       r_lat;
  mem_req_t       w_sel;
  logic [PW-1:0]  r_gidx;
  logic [NCH-1:0] r_gnt;
  logic [PW-1:0]  r_ptr;
  logic [NCH-1:0] r_mask;
  logic [NCH-1:0] r_rdy;
  logic           r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [TW-1:0]  r_timer;

  logic [NCH-1:0] w_grant;
  logic [PW-1:0]  w_gidx;
  logic           w_any;
  logic           w_take;
  logic           w_done;
  logic           w_tout;

  rr_arbiter #(
    .N  (NCH),
    .PW (PW)
  ) u_rr (
    .i_req     (ch_req),
    .i_mask    (r_mask),
    .i_ptr     (r_ptr),
    .i_rr_mode (RR_MODE != 0),
    .o_grant   (w_grant),
    .o_idx     (w_gidx),
    .o_any     (w_any)
  );

  // Pick out the granted channel's request fields for the latch
  always_comb begin
    w_sel       = '0;
    w_sel.addr  = MEM_ADDR_W'(ch_addr[int'(w_gidx)*ADDR_W +: ADDR_W]);
    w_sel.wdata = MEM_DATA_W'(ch_wdata[int'(w_gidx)*DATA_W +: DATA_W]);
    w_sel.ws    = ws_t'(ch_ws[int'(w_gidx)*2 +: 2]);
    w_sel.wr    = ch_wr[w_gidx];
  end

  // Next-state decode: grant in IDLE, finish on mem_rdy or timeout in BUSY
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_BUSY;
          w_take      = 1'b1;
        end
      end
      ARB_BUSY: begin
        // mem_rdy takes precedence over a timeout landing on the same cycle
        if (mem_rdy) begin
          w_state_nxt = ARB_IDLE;
          w_done      = 1'b1;
        end else if ((TIMEOUT > 0) && (r_timer == TW'(TLAST))) begin
          w_state_nxt = ARB_IDLE;
          w_tout      = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request latch, wait timer, rr pointer and completion pulse registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lat   <= '0;
      r_gidx  <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_mask  <= '0;
      r_rdy   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_timer <= '0;
    end else begin
      r_rdy  <= '0;
      r_mask <= '0;
      r_err  <= 1'b0;
      if (w_take) begin
        r_lat   <= w_sel;
        r_gidx  <= w_gidx;
        r_gnt   <= w_grant;
        r_timer <= '0;
      end
      if ((TIMEOUT > 0) && (r_state == ARB_BUSY) && !w_done && !w_tout) begin
        r_timer <= r_timer + TW'(1);
      end
      if (w_done || w_tout) begin
        r_rdy   <= r_gnt;
        r_mask  <= r_gnt;
        r_err   <= w_tout;
        r_rdata <= w_tout ? '0 : mem_rdata;
        r_ptr   <= (r_gidx == LAST_CH) ? '0 : r_gidx + PW'(1);
      end
    end
  end

  assign mem_req   = (r_state == ARB_BUSY);
  assign mem_addr  = ADDR_W'(r_lat.addr);
  assign mem_wdata = DATA_W'(r_lat.wdata);
  assign mem_ws    = r_lat.ws;
  assign mem_wr    = r_lat.wr;
  assign ch_rdy    = r_rdy;
  assign ch_err    = r_err;
  assign ch_rdata  = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is round-robin with TIMEOUT=4,
// instance 1 is fixed priority without timeout. A transaction-level model
// predicts every cycle's memory-side and channel-side outputs.
module tb_mem_port_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ND  = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NCH*AW-1:0] ch_addr  [ND];
  logic [NCH*DW-1:0] ch_wdata [ND];
  logic [NCH*2-1:0]  ch_ws    [ND];
  logic [NCH-1:0]    ch_wr    [ND];
  logic [NCH-1:0]    ch_req   [ND];
  logic [DW-1:0]     ch_rdata [ND];
  logic [NCH-1:0]    ch_rdy   [ND];
  logic              ch_err   [ND];
  logic [AW-1:0]     mem_addr [ND];
  logic [DW-1:0]     mem_wdata[ND];
  logic [1:0]        mem_ws   [ND];
  logic              mem_wr   [ND];
  logic              mem_req  [ND];
  logic [DW-1:0]     mem_rdata[ND];
  logic              mem_rdy  [ND];

  for (genvar d = 0; d < ND; d++) begin : g_dut
    mem_port_arbiter #(
      .NCH(NCH), .ADDR_W(AW), .DATA_W(DW),
      .RR_MODE(d == 0 ? 1 : 0), .TIMEOUT(d == 0 ? 4 : 0)
    ) u_dut (
      .clock(clock), .reset(reset),
      .ch_addr(ch_addr[d]), .ch_wdata(ch_wdata[d]), .ch_ws(ch_ws[d]),
      .ch_wr(ch_wr[d]), .ch_req(ch_req[d]), .ch_rdata(ch_rdata[d]),
      .ch_rdy(ch_rdy[d]), .ch_err(ch_err[d]),
      .mem_addr(mem_addr[d]), .mem_wdata(mem_wdata[d]), .mem_ws(mem_ws[d]),
      .mem_wr(mem_wr[d]), .mem_req(mem_req[d]),
      .mem_rdata(mem_rdata[d]), .mem_rdy(mem_rdy[d])
    );
  end

  int P_RR [ND] = '{1, 0};
  int P_TO [ND] = '{4, 0};

  // reference model state: one outstanding transaction per instance
  bit            m_busy [ND];
  int            m_g    [ND];
  int            m_t    [ND];
  int            m_mask [ND];
  int            m_ptr  [ND];
  int            m_rdy  [ND];
  bit            m_err  [ND];
  logic [DW-1:0] m_rdata[ND];
  logic [AW-1:0] m_addr [ND];
  logic [DW-1:0] m_wdata[ND];
  logic [1:0]    m_ws   [ND];
  logic          m_wr   [ND];

  // stimulus bookkeeping
  bit mprev [ND];
  int mcnt  [ND];
  int mwait [ND];
  bit drop_next [ND][NCH];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    m_busy[d] = 0; m_g[d] = 0; m_t[d] = 0; m_mask[d] = -1; m_ptr[d] = 0;
    m_rdy[d] = -1; m_err[d] = 0; m_rdata[d] = '0;
    m_addr[d] = '0; m_wdata[d] = '0; m_ws[d] = '0; m_wr[d] = 1'b0;
  endtask

  // one clock edge of the arbiter, from the inputs currently applied
  task automatic model_step(input int d);
    int c, pick, fin;
    pick = -1;
    fin  = -1;
    if (!m_busy[d]) begin
      for (int k = 0; k < NCH; k++) begin
        c = (P_RR[d] != 0) ? (m_ptr[d] + k) % NCH : k;
        if (pick < 0 && ch_req[d][c] && c != m_mask[d]) pick = c;
      end
      if (pick >= 0) begin
        m_busy[d]  = 1;
        m_g[d]     = pick;
        m_t[d]     = 0;
        m_addr[d]  = ch_addr[d][pick*AW +: AW];
        m_wdata[d] = ch_wdata[d][pick*DW +: DW];
        m_ws[d]    = ch_ws[d][pick*2 +: 2];
        m_wr[d]    = ch_wr[d][pick];
      end
    end else if (mem_rdy[d]) begin
      fin = m_g[d]; m_err[d] = 0; m_rdata[d] = mem_rdata[d];
    end else if (P_TO[d] > 0 && m_t[d] == P_TO[d] - 1) begin
      fin = m_g[d]; m_err[d] = 1; m_rdata[d] = '0;
    end else begin
      m_t[d]++;
    end
    if (fin >= 0) begin
      m_busy[d] = 0;
      m_ptr[d]  = (fin + 1) % NCH;
    end
    m_rdy[d]  = fin;
    m_mask[d] = fin;
  endtask

  task automatic check_outputs(input int d);
    logic [NCH-1:0] e_rdy;
    e_rdy = '0;
    if (m_rdy[d] >= 0) e_rdy[m_rdy[d]] = 1'b1;
    chk($sformatf("d%0d_mem_req", d), mem_req[d], m_busy[d]);
    chk($sformatf("d%0d_ch_rdy", d), ch_rdy[d], e_rdy);
    if (m_rdy[d] >= 0) begin
      chk($sformatf("d%0d_ch_err", d), ch_err[d], m_err[d]);
      chk($sformatf("d%0d_ch_rdata", d), ch_rdata[d], m_rdata[d]);
    end
    if (m_busy[d]) begin
      chk($sformatf("d%0d_mem_addr", d), mem_addr[d], m_addr[d]);
      chk($sformatf("d%0d_mem_wdata", d), mem_wdata[d], m_wdata[d]);
      chk($sformatf("d%0d_mem_ws", d), mem_ws[d], m_ws[d]);
      chk($sformatf("d%0d_mem_wr", d), mem_wr[d], m_wr[d]);
    end
  endtask

  task automatic tick();
    for (int d = 0; d < ND; d++) model_step(d);
    @(posedge clock);
    #1;
    for (int d = 0; d < ND; d++) check_outputs(d);
  endtask

  task automatic idle_inputs(input int d);
    ch_addr[d] = '0; ch_wdata[d] = '0; ch_ws[d] = '0; ch_wr[d] = '0;
    ch_req[d] = '0; mem_rdata[d] = '0; mem_rdy[d] = 1'b0;
    mprev[d] = 0; mcnt[d] = 0; mwait[d] = 0;
    for (int c = 0; c < NCH; c++) drop_next[d][c] = 0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      model_reset(d);
      check_outputs(d);
      chk($sformatf("d%0d_rst_addr", d), mem_addr[d], 0);
      chk($sformatf("d%0d_rst_wdata", d), mem_wdata[d], 0);
      chk($sformatf("d%0d_rst_ws", d), mem_ws[d], 0);
      chk($sformatf("d%0d_rst_wr", d), mem_wr[d], 0);
      chk($sformatf("d%0d_rst_err", d), ch_err[d], 0);
      chk($sformatf("d%0d_rst_rdata", d), ch_rdata[d], 0);
      idle_inputs(d);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_ch(input int d, input int c, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [1:0] ws, input logic wr);
    ch_addr[d][c*AW +: AW]  = a;
    ch_wdata[d][c*DW +: DW] = wd;
    ch_ws[d][c*2 +: 2]      = ws;
    ch_wr[d][c]             = wr;
  endtask

  // random requesters and a memory with 0..5 wait cycles
  task automatic drive_random(input int d);
    if (m_busy[d]) begin
      if (!mprev[d]) begin
        mcnt[d]  = 0;
        mwait[d] = int'($urandom_range(5, 0));
      end
      mem_rdy[d] = (mcnt[d] == mwait[d]);
      mcnt[d]++;
    end else begin
      mem_rdy[d] = ($urandom_range(7, 0) == 0);
    end
    mem_rdata[d] = $urandom;
    mprev[d]     = m_busy[d];
    for (int c = 0; c < NCH; c++) begin
      if (ch_req[d][c]) begin
        if (m_rdy[d] == c) begin
          if ($urandom_range(1, 0) == 0) ch_req[d][c] = 1'b0;
          else drop_next[d][c] = 1;
        end else if (drop_next[d][c]) begin
          ch_req[d][c] = 1'b0;
          drop_next[d][c] = 0;
        end else if ($urandom_range(15, 0) == 0) begin
          ch_req[d][c] = 1'b0;
        end else if ($urandom_range(7, 0) == 0) begin
          ch_addr[d][c*AW +: AW] = $urandom;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        set_ch(d, c, $urandom, $urandom, 2'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
        ch_req[d][c] = 1'b1;
      end
    end
  endtask

  // both channels held, zero-wait memory: grants must alternate 0,1,0,1...
  task automatic alternation(input int d, input string name);
    int n;
    n = 0;
    ch_req[d] = 2'b11;
    set_ch(d, 0, 32'h1000, 32'h11, 2'd2, 1'b0);
    set_ch(d, 1, 32'h2000, 32'h22, 2'd1, 1'b1);
    for (int i = 0; i < 80 && n < 8; i++) begin
      mem_rdy[d]   = m_busy[d];
      mem_rdata[d] = $urandom;
      tick();
      if (ch_rdy[d] != '0) begin
        chk($sformatf("%s_order%0d", name, n), ch_rdy[d], 64'd1 << (n % 2));
        n++;
      end
    end
    chk($sformatf("%s_count", name), n, 8);
    idle_inputs(d);
    tick();
    tick();
  endtask

  initial begin
    int cnt, got, pulses;
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      idle_inputs(d);
      model_reset(d);
    end
    do_reset();

    // single read on ch0, memory answers on the third mem_req cycle
    set_ch(0, 0, 32'h100, 32'h0, 2'd2, 1'b0);
    ch_req[0] = 2'b01;
    tick();
    chk("t1_mem_req", mem_req[0], 1);
    chk("t1_mem_addr", mem_addr[0], 32'h100);
    chk("t1_mem_wr", mem_wr[0], 0);
    tick();
    tick();
    mem_rdy[0]   = 1'b1;
    mem_rdata[0] = 32'hDEADBEEF;
    tick();
    mem_rdy[0] = 1'b0;
    ch_req[0]  = 2'b00;
    chk("t1_rdy", ch_rdy[0], 2'b01);
    chk("t1_rdata", ch_rdata[0], 32'hDEADBEEF);
    chk("t1_err", ch_err[0], 0);
    tick();
    chk("t1_rdy_gone", ch_rdy[0], 0);

    // round-robin alternation from ptr=0
    do_reset();
    alternation(0, "t2_rr");

    // fixed priority: ch1 only wins in ch0's masked cycle
    do_reset();
    alternation(1, "t3_fp");

    // timeout: ch1 write never answered
    set_ch(0, 1, 32'h200, 32'h55, 2'd2, 1'b1);
    ch_req[0] = 2'b10;
    cnt = 0;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (mem_req[0]) cnt++;
      if (ch_rdy[0] != '0) begin
        got = 1;
        chk("t4_rdy", ch_rdy[0], 2'b10);
        chk("t4_err", ch_err[0], 1);
        chk("t4_rdata", ch_rdata[0], 0);
        ch_req[0] = 2'b00;
      end
    end
    chk("t4_seen", got, 1);
    chk("t4_req_cycles", cnt, 4);
    set_ch(0, 0, 32'h10, 32'h0, 2'd0, 1'b0);
    ch_req[0] = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      mem_rdy[0]   = m_busy[0];
      mem_rdata[0] = 32'hCAFE0001;
      tick();
      if (ch_rdy[0] != '0) begin
        got = 1;
        chk("t4_next_rdy", ch_rdy[0], 2'b01);
        chk("t4_next_err", ch_err[0], 0);
        ch_req[0] = 2'b00;
      end
    end
    chk("t4_next_seen", got, 1);
    mem_rdy[0] = 1'b0;
    tick();

    // reset in the middle of a transaction, then a stray mem_rdy
    set_ch(0, 0, 32'h400, 32'h0, 2'd2, 1'b0);
    ch_req[0] = 2'b01;
    tick();
    tick();
    chk("t5_busy", mem_req[0], 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_req", mem_req[0], 0);
    chk("t5_async_rdy", ch_rdy[0], 0);
    do_reset();
    mem_rdy[0]   = 1'b1;
    mem_rdata[0] = 32'h12345678;
    tick();
    mem_rdy[0] = 1'b0;
    chk("t5_no_rdy", ch_rdy[0], 0);
    tick();

    // requester drops req and changes address while BUSY
    set_ch(0, 0, 32'h300, 32'h0, 2'd2, 1'b0);
    ch_req[0] = 2'b01;
    tick();
    ch_req[0] = 2'b00;
    ch_addr[0][0 +: AW] = 32'h999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_addr_held", mem_addr[0], 32'h300);
    end
    mem_rdy[0]   = 1'b1;
    mem_rdata[0] = 32'hA5A5A5A5;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_rdy[0] = 1'b0;
      if (ch_rdy[0] == 2'b01) pulses++;
      if (i == 0) chk("t6_err", ch_err[0], 0);
    end
    chk("t6_pulses", pulses, 1);

    // randomized traffic on both instances
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < ND; d++) drive_random(d);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
